// File: rtl/nn_layer_seq.sv
// nn_layer_seq -- sequences one inference through L layers of a neural network.
//
// For each accepted input vector the sequencer pulses layer_start once per layer,
// waits for the layer controller's layer_done, and steps layer_id and the
// ping-pong activation buffer select. After the last layer the result is offered
// on output_valid until downstream takes it with output_ready.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. input_ready is high only in S_IDLE. output_valid
// is high only in S_OUTPUT and, once high, stays high with all other outputs
// unchanged until output_ready is seen.
//
// Parameters:
//   L   number of layers per inference (L >= 2)
//   CW  width of the latency counter
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   input_valid   upstream offers a new input vector
//   input_ready   sequencer can accept a new inference (S_IDLE)
//   output_valid  final layer result available (S_OUTPUT)
//   output_ready  downstream accepts the result
//   layer_start   one-cycle start pulse to the layer controller (S_START)
//   layer_id      index of the active layer
//   layer_done    layer controller finished the active layer
//   buf_sel       activation buffer the layer reads; it writes ~buf_sel
//   busy          high in every state except S_IDLE
//   err           sticky flag: layer_done seen outside S_WAIT
//   cycle_count   inference latency in cycles
//
// Build option: define NN_SEQ_PERF_CNT_EN to build the latency counter. Without
// it cycle_count is tied to zero and no counter register exists.
//
// Every output except cycle_count is a decode of registered state, so there is
// no combinational path from any input to any output.

module nn_layer_seq #(
    parameter int L  = 6,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 input_valid,
    output logic                 input_ready,
    output logic                 output_valid,
    input  logic                 output_ready,
    output logic                 layer_start,
    output logic [$clog2(L)-1:0] layer_id,
    input  logic                 layer_done,
    output logic                 buf_sel,
    output logic                 busy,
    output logic                 err,
    output logic [CW-1:0]        cycle_count
);

    localparam int LW = $clog2(L);
    localparam logic [LW-1:0] LAST_LAYER = LW'(L - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_WAIT   = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] layer_id_q, layer_id_d;
    logic          buf_sel_q, buf_sel_d;
    logic          err_q, err_d;
    logic          accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            layer_id_q <= '0;
            buf_sel_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            layer_id_q <= layer_id_d;
            buf_sel_q  <= buf_sel_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        layer_id_d = layer_id_q;
        buf_sel_d  = buf_sel_q;
        err_d      = err_q;
        accept     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (input_valid) begin
                    accept     = 1'b1;
                    state_d    = S_START;
                    layer_id_d = '0;
                    buf_sel_d  = 1'b0;
                end
            end
            S_START: begin
                // The start pulse lasts exactly one cycle; any layer_done seen
                // here cannot belong to the layer just started.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (layer_done) begin
                    if (layer_id_q == LAST_LAYER) begin
                        state_d = S_OUTPUT;
                    end else begin
                        state_d    = S_START;
                        layer_id_d = layer_id_q + 1'b1;
                        buf_sel_d  = ~buf_sel_q;
                    end
                end
            end
            S_OUTPUT: begin
                if (output_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Acceptance clears the error, but a stray layer_done in the same
        // cycle wins so the error is never silently lost.
        if (accept) begin
            err_d = 1'b0;
        end
        if (layer_done && (state_q != S_WAIT)) begin
            err_d = 1'b1;
        end
    end

    assign input_ready  = (state_q == S_IDLE);
    assign layer_start  = (state_q == S_START);
    assign output_valid = (state_q == S_OUTPUT);
    assign busy         = (state_q != S_IDLE);
    assign layer_id     = layer_id_q;
    assign buf_sel      = buf_sel_q;
    assign err          = err_q;

`ifdef NN_SEQ_PERF_CNT_EN
    logic [CW-1:0] cnt_q;

    // Counts cycles spent in S_START/S_WAIT of the current inference; it
    // saturates rather than wrapping so an overflow reads as "at least max".
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (((state_q == S_START) || (state_q == S_WAIT)) && (cnt_q != {CW{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cycle_count = cnt_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: doc/nn_layer_seq.md
NN_LAYER_SEQ -- requirements
Module: nn_layer_seq

Interface
REQ-001 Parameter: L, default 6, number of layers sequenced per inference (L>=2).
REQ-002 Parameter: CW, default 16, width of the performance cycle counter.
REQ-003 Port: clk  input  1  single clock; all logic samples on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: input_valid  input  1  upstream has a new input vector.
REQ-006 Port: input_ready  output  1  sequencer can accept a new inference.
REQ-007 Port: output_valid  output  1  final layer result available.
REQ-008 Port: output_ready  input  1  downstream accepts the result.
REQ-009 Port: layer_start  output  1  one-cycle start pulse to the layer controller.
REQ-010 Port: layer_id  output  $clog2(L)  index of the active layer.
REQ-011 Port: layer_done  input  1  active layer controller finished its layer.
REQ-012 Port: buf_sel  output  1  ping-pong activation buffer select; the layer reads buf_sel and writes ~buf_sel.
REQ-013 Port: busy  output  1  high in every state except S_IDLE.
REQ-014 Port: err  output  1  sticky protocol-error flag.
REQ-015 Port: cycle_count  output  CW  inference latency in cycles.

Function
REQ-016 FSM states: S_IDLE, S_START, S_WAIT, S_OUTPUT; exactly one is active per cycle.
REQ-017 S_IDLE: input_ready=1; input_valid=1 -> S_START, layer_id<=0, buf_sel<=0.
REQ-018 S_START: layer_start=1 for exactly one cycle -> S_WAIT unconditionally.
REQ-019 S_WAIT, layer_done=1, layer_id<L-1: -> S_START, layer_id<=layer_id+1, buf_sel<=~buf_sel.
REQ-020 S_WAIT, layer_done=1, layer_id==L-1: -> S_OUTPUT; layer_id and buf_sel hold.
REQ-021 S_OUTPUT: output_valid=1, held stable until output_ready=1, then -> S_IDLE.
REQ-022 Latency: input accepted at cycle t -> layer_start at t+1; layer_done at cycle d -> next layer_start or output_valid at d+1.
REQ-023 layer_done is ignored in S_START (same cycle as layer_start) and sets err.
REQ-024 layer_done in S_IDLE or S_OUTPUT is ignored for sequencing and sets err.
REQ-025 err clears only on reset or on input acceptance in S_IDLE; acceptance in the same cycle as a stray layer_done leaves err=1.
REQ-026 input_ready is 0 in all states except S_IDLE; input_valid outside S_IDLE has no effect.
REQ-027 All outputs except cycle_count are registered-state decodes with no combinational path from any input.

Reset
REQ-028 reset=1 at a clock edge forces S_IDLE, layer_id=0, buf_sel=0, err=0, cycle_count=0 at any point, including mid-inference.
REQ-029 During and immediately after reset: input_ready=1, output_valid=0, layer_start=0, busy=0.
REQ-030 Any layer_done arriving in the cycle reset is asserted is discarded without setting err.

Configuration
REQ-031 Macro NN_SEQ_PERF_CNT_EN defined: cycle_count clears to 0 on input acceptance, increments once per cycle in S_START/S_WAIT, saturates at 2^CW-1, and freezes in S_OUTPUT and S_IDLE.
REQ-032 Macro NN_SEQ_PERF_CNT_EN undefined: cycle_count is tied to 0 and no counter register is synthesized; the port remains present.

Verification
REQ-033 L=6, accept at cycle 0, layer_done returned 3 cycles after each layer_start -> layer_start at cycles 1,5,9,13,17,21; output_valid at 25; cycle_count=24 (PERF on).
REQ-034 Same flow -> layer_id steps 0..5 and buf_sel toggles 0,1,0,1,0,1 at each layer_start; output_ready held low 4 cycles keeps output_valid=1 and all outputs stable.
REQ-035 layer_done in S_IDLE, then in the S_START cycle -> err=1, no state change; next input acceptance -> err=0.
REQ-036 reset asserted during layer 3 S_WAIT -> next cycle S_IDLE, layer_id=0, buf_sel=0, input_ready=1; a new inference then completes normally.
REQ-037 CW=4, layers held 10 cycles each -> cycle_count saturates at 15 and does not wrap.
REQ-038 Macro undefined, REQ-033 stimulus -> identical handshake timing, cycle_count=0 throughout.
